// File: rtl/mcu_debug_ctrl.sv
// ---------------------------------------------------------------------------
// mcu_debug_ctrl : debug command sequencer between command decoder and MCU,
//                  with breakpoints, multi-step, handshake timeout. Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module mcu_debug_ctrl #(
  parameter int ADDR_W = 32,
  parameter int NUM_BP = 8,
  parameter int STEP_W = 8,
  parameter int TMO_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_fn,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_data,
  input  logic [ADDR_W-1:0] pc,
  input  logic              mcu_busy,
  input  logic [31:0]       mcu_rdata,
  output logic              mcu_pause,
  output logic              mcu_resume,
  output logic              mcu_reset,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              rf_rd,
  output logic              rf_wr,
  output logic [ADDR_W-1:0] mcu_addr,
  output logic [31:0]       mcu_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_err,
  output logic              rsp_evt,
  output logic [31:0]       rsp_data,
  output logic              paused,
  output logic              bp_hit
);

  localparam int IDX_W = (NUM_BP > 1) ? $clog2(NUM_BP) : 1;

  localparam logic [3:0] FN_NONE   = 4'h0;
  localparam logic [3:0] FN_PAUSE  = 4'h1;
  localparam logic [3:0] FN_RESUME = 4'h2;
  localparam logic [3:0] FN_STEP   = 4'h3;
  localparam logic [3:0] FN_RESET  = 4'h4;
  localparam logic [3:0] FN_STATUS = 4'h5;
  localparam logic [3:0] FN_BP_ADD = 4'h6;
  localparam logic [3:0] FN_BP_RM  = 4'h7;
  localparam logic [3:0] FN_MEM_RD = 4'h8;
  localparam logic [3:0] FN_MEM_WR = 4'h9;
  localparam logic [3:0] FN_REG_RD = 4'hA;
  localparam logic [3:0] FN_REG_WR = 4'hB;
  localparam logic [3:0] FN_BP_CLR = 4'hC;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACK} state_t;
  typedef enum logic [2:0] {OP_PAUSE, OP_RESUME, OP_RESET, OP_MRD, OP_MWR, OP_RRD, OP_RWR} op_t;

  state_t state, state_nxt;
  op_t    op;

  logic [ADDR_W-1:0] bp_addr [NUM_BP];
  logic [NUM_BP-1:0] bp_valid;
  logic [NUM_BP-1:0] cmd_match, pc_match;
  logic              free_found;
  logic [IDX_W-1:0]  free_idx;
  logic [3:0]        valid_count;

  logic              hit_pending, hit_now;
  logic [ADDR_W-1:0] hit_pc, skip_pc;
  logic              skip_valid;
  logic [31:0]       hit_pc_ext;
  logic              step_active, evt_active;
  logic [STEP_W-1:0] step_cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              tmo_exp, accept, svc, hs_done, tmo_abort;
  logic              fin, fin_err, fin_evt;
  logic [31:0]       fin_data, status_word;

  always_comb begin
    cmd_match   = '0;
    pc_match    = '0;
    free_found  = 1'b0;
    free_idx    = '0;
    valid_count = '0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      cmd_match[i] = bp_valid[i] && (bp_addr[i] == cmd_addr);
      pc_match[i]  = bp_valid[i] && (bp_addr[i] == pc);
      valid_count  = valid_count + 4'(bp_valid[i]);
      if (!bp_valid[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  // The pc a RESUME started from is exempt until the MCU has moved off it.
  assign hit_now = !paused && !step_active && (|pc_match) && !(skip_valid && (pc == skip_pc));
  assign tmo_exp = (tmo_cnt == {TMO_W{1'b1}});
  assign status_word = {16'b0, 4'b0, valid_count, 6'b0, hit_pending, paused};

  always_comb begin
    hit_pc_ext = '0;
    hit_pc_ext[ADDR_W-1:0] = hit_pc;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    cmd_ready  = 1'b0;
    accept     = 1'b0;
    svc        = 1'b0;
    hs_done    = 1'b0;
    tmo_abort  = 1'b0;
    fin        = 1'b0;
    fin_err    = 1'b0;
    fin_evt    = 1'b0;
    fin_data   = '0;
    mcu_pause  = 1'b0;
    mcu_resume = 1'b0;
    mcu_reset  = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    rf_rd      = 1'b0;
    rf_wr      = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = !rsp_valid && !hit_pending && !hit_now;
        accept    = cmd_valid && cmd_ready;
        svc       = !rsp_valid && hit_pending;
        if (svc) begin
          if (paused) begin
            fin      = 1'b1;
            fin_evt  = 1'b1;
            fin_data = hit_pc_ext;
          end else begin
            state_nxt = S_REQ;
          end
        end else if (accept) begin
          case (cmd_fn)
            FN_NONE: ;
            FN_PAUSE:  if (paused) fin = 1'b1; else state_nxt = S_REQ;
            FN_RESUME: if (!paused) fin = 1'b1; else state_nxt = S_REQ;
            FN_STEP, FN_MEM_RD, FN_MEM_WR, FN_REG_RD, FN_REG_WR: begin
              if (!paused) begin
                fin     = 1'b1;
                fin_err = 1'b1;
              end else begin
                state_nxt = S_REQ;
              end
            end
            FN_RESET:  state_nxt = S_REQ;
            FN_STATUS: begin
              fin      = 1'b1;
              fin_data = status_word;
            end
            FN_BP_ADD: begin
              fin     = 1'b1;
              fin_err = !(|cmd_match) && !free_found;
            end
            FN_BP_RM: begin
              fin     = 1'b1;
              fin_err = !(|cmd_match);
            end
            FN_BP_CLR: fin = 1'b1;
            default: begin
              fin     = 1'b1;
              fin_err = 1'b1;
            end
          endcase
        end
      end
      S_REQ: begin
        mcu_pause  = (op == OP_PAUSE);
        mcu_resume = (op == OP_RESUME);
        mcu_reset  = (op == OP_RESET);
        mem_rd     = (op == OP_MRD);
        mem_wr     = (op == OP_MWR);
        rf_rd      = (op == OP_RRD);
        rf_wr      = (op == OP_RWR);
        if (mcu_busy)     state_nxt = S_ACK;
        else if (tmo_exp) tmo_abort = 1'b1;
      end
      S_ACK: begin
        if (!mcu_busy)    hs_done   = 1'b1;
        else if (tmo_exp) tmo_abort = 1'b1;
        if (hs_done) begin
          if (step_active && ((op == OP_RESUME) || (step_cnt != STEP_W'(1)))) begin
            state_nxt = S_REQ;
          end else begin
            state_nxt = S_IDLE;
            fin       = 1'b1;
            fin_evt   = evt_active;
            if ((op == OP_MRD) || (op == OP_RRD)) fin_data = mcu_rdata;
            else if (evt_active)                  fin_data = hit_pc_ext;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (tmo_abort) begin
      state_nxt = S_IDLE;
      fin       = 1'b1;
      fin_err   = 1'b1;
      fin_evt   = evt_active;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      paused      <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_evt     <= 1'b0;
      rsp_data    <= '0;
      bp_hit      <= 1'b0;
      bp_valid    <= '0;
      for (int i = 0; i < NUM_BP; i++) bp_addr[i] <= '0;
      hit_pending <= 1'b0;
      hit_pc      <= '0;
      skip_pc     <= '0;
      skip_valid  <= 1'b0;
      op          <= OP_PAUSE;
      step_active <= 1'b0;
      evt_active  <= 1'b0;
      step_cnt    <= '0;
      tmo_cnt     <= '0;
      mcu_addr    <= '0;
      mcu_wdata   <= '0;
    end else begin
      bp_hit <= 1'b0;
      if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;
      if (skip_valid && (pc != skip_pc)) skip_valid <= 1'b0;
      if (hit_now && !hit_pending) begin
        hit_pending <= 1'b1;
        hit_pc      <= pc;
      end
      if ((state_nxt == S_REQ) && (state != S_REQ)) tmo_cnt <= '0;
      else if (state != S_IDLE)                      tmo_cnt <= tmo_cnt + 1'b1;
      if (fin) begin
        rsp_valid <= 1'b1;
        rsp_err   <= fin_err;
        rsp_evt   <= fin_evt;
        rsp_data  <= fin_data;
      end

      if (svc) begin
        bp_hit <= 1'b1;
        if (paused) hit_pending <= 1'b0;
        else begin
          op         <= OP_PAUSE;
          evt_active <= 1'b1;
        end
      end else if (accept) begin
        mcu_addr  <= cmd_addr;
        mcu_wdata <= cmd_data;
        case (cmd_fn)
          FN_PAUSE:  op <= OP_PAUSE;
          FN_RESUME: begin
            op <= OP_RESUME;
            if (paused) begin
              skip_pc    <= pc;
              skip_valid <= 1'b1;
            end
          end
          FN_STEP: begin
            op          <= OP_RESUME;
            step_active <= paused;
            step_cnt    <= (cmd_data[STEP_W-1:0] == '0) ? STEP_W'(1) : cmd_data[STEP_W-1:0];
          end
          FN_RESET:  op <= OP_RESET;
          FN_MEM_RD: op <= OP_MRD;
          FN_MEM_WR: op <= OP_MWR;
          FN_REG_RD: op <= OP_RRD;
          FN_REG_WR: op <= OP_RWR;
          FN_BP_ADD: begin
            if (!(|cmd_match) && free_found) begin
              bp_valid[free_idx] <= 1'b1;
              bp_addr[free_idx]  <= cmd_addr;
            end
          end
          FN_BP_RM:  bp_valid <= bp_valid & ~cmd_match;
          FN_BP_CLR: bp_valid <= '0;
          default: ;
        endcase
      end

      if (tmo_abort) begin
        step_active <= 1'b0;
        evt_active  <= 1'b0;
        if (evt_active) hit_pending <= 1'b0;
      end else if (hs_done) begin
        case (op)
          OP_PAUSE: begin
            paused <= 1'b1;
            if (step_active) begin
              if (step_cnt == STEP_W'(1)) step_active <= 1'b0;
              else begin
                step_cnt <= step_cnt - 1'b1;
                op       <= OP_RESUME;
              end
            end
            if (evt_active) begin
              evt_active  <= 1'b0;
              hit_pending <= 1'b0;
            end
          end
          OP_RESUME: begin
            paused <= 1'b0;
            if (step_active) op <= OP_PAUSE;
          end
          OP_RESET: paused <= 1'b0;
          default: ;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mcu_debug_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mcu_debug_ctrl : scoreboard bench for mcu_debug_ctrl with a simple MCU
//                     responder model. Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_mcu_debug_ctrl;

  localparam int NBP = 4;
  localparam int TW  = 6;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid, cmd_ready;
  logic [3:0]  cmd_fn;
  logic [31:0] cmd_addr, cmd_data, pc;
  logic        mcu_busy;
  logic [31:0] mcu_rdata;
  logic        mcu_pause, mcu_resume, mcu_reset, mem_rd, mem_wr, rf_rd, rf_wr;
  logic [31:0] mcu_addr, mcu_wdata;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_evt;
  logic [31:0] rsp_data;
  logic        paused, bp_hit;

  always #5 clk = ~clk;

  mcu_debug_ctrl #(.ADDR_W(32), .NUM_BP(NBP), .STEP_W(8), .TMO_W(TW)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_fn(cmd_fn), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .pc(pc),
    .mcu_busy(mcu_busy), .mcu_rdata(mcu_rdata), .mcu_pause(mcu_pause),
    .mcu_resume(mcu_resume), .mcu_reset(mcu_reset), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .rf_rd(rf_rd), .rf_wr(rf_wr), .mcu_addr(mcu_addr), .mcu_wdata(mcu_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_err(rsp_err), .rsp_evt(rsp_evt),
    .rsp_data(rsp_data), .paused(paused), .bp_hit(bp_hit)
  );

  typedef struct packed {
    logic        err;
    logic        evt;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          n_vec = 0, n_err = 0;
  int          n_res = 0, n_pau = 0, n_hit = 0;
  bit          stuck = 1'b0;
  logic [31:0] rd_val = 32'hDEADBEEF;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, req);
    end
  endtask

  // MCU responder: acknowledges any request two cycles long, returns rd_val.
  initial begin
    mcu_busy  = 1'b0;
    mcu_rdata = '0;
    forever begin
      @(negedge clk);
      if (!stuck && reset_n && !mcu_busy &&
          (mcu_pause | mcu_resume | mcu_reset | mem_rd | mem_wr | rf_rd | rf_wr)) begin
        if (mcu_pause)  n_pau++;
        if (mcu_resume) n_res++;
        mcu_busy = 1'b1;
        repeat (2) @(negedge clk);
        mcu_rdata = rd_val;
        mcu_busy  = 1'b0;
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bp_hit) n_hit++;
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", {rsp_err, rsp_evt, 30'b0}, 32'hFFFFFFFF);
        end else begin
          e = exp_q.pop_front();
          check("rsp_flags", {30'b0, rsp_err, rsp_evt}, {30'b0, e.err, e.evt});
          check("rsp_data", rsp_data, e.data);
        end
      end
    end
  end

  task automatic wait_rsp(input string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check({nm, "_rsp_timeout"}, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic issue(input string nm, input logic [3:0] fn, input logic [31:0] addr,
                       input logic [31:0] data, input bit push, input logic e_err,
                       input logic [31:0] e_data);
    int n = 0;
    @(negedge clk);
    cmd_fn    = fn;
    cmd_addr  = addr;
    cmd_data  = data;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) check({nm, "_accept_timeout"}, 32'd0, 32'd1);
    else if (push) exp_q.push_back('{err: e_err, evt: 1'b0, data: e_data});
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    if (push) wait_rsp(nm);
  endtask

  initial begin
    int r0, p0, h0;
    cmd_valid = 1'b0;
    cmd_fn    = '0;
    cmd_addr  = '0;
    cmd_data  = '0;
    pc        = 32'h1000;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_flags", {26'b0, rsp_valid, rsp_err, rsp_evt, bp_hit, paused, cmd_ready},
          32'h1);
    check("reset_reqs", {25'b0, mcu_pause, mcu_resume, mcu_reset, mem_rd, mem_wr, rf_rd, rf_wr},
          32'h0);
    check("reset_rsp_data", rsp_data, 32'h0);
    reset_n = 1'b1;

    issue("add_100", 4'h6, 32'h100, 0, 1, 0, 0);
    issue("add_200", 4'h6, 32'h200, 0, 1, 0, 0);
    issue("add_dup", 4'h6, 32'h100, 0, 1, 0, 0);
    issue("status2", 4'h5, 0, 0, 1, 0, 32'h0000_0200);
    issue("add_300", 4'h6, 32'h300, 0, 1, 0, 0);
    issue("add_400", 4'h6, 32'h400, 0, 1, 0, 0);
    issue("add_full", 4'h6, 32'h500, 0, 1, 1, 0);
    issue("status4", 4'h5, 0, 0, 1, 0, 32'h0000_0400);
    issue("rm_300", 4'h7, 32'h300, 0, 1, 0, 0);
    issue("rm_miss", 4'h7, 32'h300, 0, 1, 1, 0);
    issue("rm_400", 4'h7, 32'h400, 0, 1, 0, 0);
    issue("step_run", 4'h3, 0, 3, 1, 1, 0);
    issue("memrd_run", 4'h8, 32'h40, 0, 1, 1, 0);

    // running into breakpoint 0x200
    p0 = n_pau;
    exp_q.push_back('{err: 1'b0, evt: 1'b1, data: 32'h200});
    @(negedge clk);
    pc = 32'h200;
    wait_rsp("hit1");
    check("hit1_pulses", 32'(n_hit), 32'd1);
    check("hit1_pause_reqs", 32'(n_pau - p0), 32'd1);
    check("hit1_paused", {31'b0, paused}, 32'd1);
    issue("status_paused", 4'h5, 0, 0, 1, 0, 32'h0000_0201);

    // resume from the breakpoint pc must not retrigger
    issue("resume", 4'h2, 0, 0, 1, 0, 0);
    repeat (5) @(negedge clk);
    check("no_retrigger", 32'(n_hit), 32'd1);
    check("running", {31'b0, paused}, 32'd0);
    exp_q.push_back('{err: 1'b0, evt: 1'b1, data: 32'h200});
    pc = 32'h204;
    @(negedge clk);
    pc = 32'h200;
    wait_rsp("hit2");
    check("hit2_pulses", 32'(n_hit), 32'd2);

    r0 = n_res; p0 = n_pau; h0 = n_hit;
    issue("step3", 4'h3, 0, 3, 1, 0, 0);
    check("step3_resumes", 32'(n_res - r0), 32'd3);
    check("step3_pauses", 32'(n_pau - p0), 32'd3);
    check("step3_no_hit", 32'(n_hit - h0), 32'd0);
    r0 = n_res; p0 = n_pau;
    issue("step0", 4'h3, 0, 0, 1, 0, 0);
    check("step0_pairs", 32'(n_res - r0 + n_pau - p0), 32'd2);

    issue("memrd", 4'h8, 32'h40, 0, 1, 0, 32'hDEADBEEF);
    check("memrd_addr", mcu_addr, 32'h40);
    rd_val = 32'h0BAD_F00D;
    issue("regrd", 4'hA, 32'h3, 0, 1, 0, 32'h0BAD_F00D);
    issue("regwr", 4'hB, 32'h3, 32'h55AA, 1, 0, 0);
    check("regwr_wdata", mcu_wdata, 32'h55AA);
    p0 = n_pau;
    issue("pause_paused", 4'h1, 0, 0, 1, 0, 0);
    check("pause_no_req", 32'(n_pau - p0), 32'd0);

    stuck = 1'b1;
    issue("memrd_tmo", 4'h8, 32'h44, 0, 1, 1, 0);
    stuck = 1'b0;

    issue("bp_clr", 4'hC, 0, 0, 1, 0, 0);
    issue("status_clr", 4'h5, 0, 0, 1, 0, 32'h0000_0001);
    issue("add_500", 4'h6, 32'h500, 0, 1, 0, 0);
    issue("status_one", 4'h5, 0, 0, 1, 0, 32'h0000_0101);

    // async reset while the MCU has not yet acked a write
    stuck = 1'b1;
    issue("memwr_hang", 4'h9, 32'h80, 32'h1234, 0, 0, 0);
    begin
      int n = 0;
      while (!mem_wr && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    check("memwr_req", {31'b0, mem_wr}, 32'd1);
    #2 reset_n = 1'b0;
    #1 check("async_reset", {29'b0, mem_wr, paused, cmd_ready}, 32'b001);
    @(negedge clk);
    reset_n = 1'b1;
    stuck = 1'b0;
    issue("status_after_rst", 4'h5, 0, 0, 1, 0, 32'h0000_0000);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
